video_pattern_gen: RTL

- Upstream source for my_hdmi. Generates 640x480@60 timing (800x525 total, 25.2 MHz pixel clock) and a selectable RGB test pattern.
- Outputs feed the three TMDS encoders directly: hsync/vsync as channel-0 control bits, plus de and 8-bit R/G/B.
- A debounced push-button cycles through four patterns. A pattern change takes effect only at a frame boundary, so no frame tears.

---
 rtl/video_timing_pkg.sv | 54 +++++
 rtl/video_pattern_gen_btn_debounce.sv | 58 +++++
 rtl/video_pattern_gen.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Purpose: shared 640x480@60 timing defaults, pattern encodings and pixel helpers.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package video_timing_pkg;

    // Both raster counters are 10 bits wide: 800 and 525 both fit.
    localparam int CNT_W = 10;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int DEBOUNCE_CYCLES_DEF = 252000;

    localparam int H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
    localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_CHECK = 2'd1,
        PAT_RAMP  = 2'd2,
        PAT_WHITE = 2'd3
    } pattern_e;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    localparam rgb_t RGB_BLACK = '{red: 8'h00, green: 8'h00, blue: 8'h00};
    localparam rgb_t RGB_WHITE = '{red: 8'hFF, green: 8'hFF, blue: 8'hFF};

    // Bar order white, yellow, cyan, green, magenta, red, blue, black falls out
    // of the bar index bits: red off when bar[1], green off when bar[2],
    // blue off when bar[0].
    function automatic rgb_t bar_colour(input logic [2:0] bar);
        rgb_t c;
        c.red   = bar[1] ? 8'h00 : 8'hFF;
        c.green = bar[2] ? 8'h00 : 8'hFF;
        c.blue  = bar[0] ? 8'h00 : 8'hFF;
        return c;
    endfunction

endpackage

// File: rtl/video_pattern_gen_btn_debounce.sv
// Purpose: synchronise and debounce an active-low button, pulse once per accepted press.
// Latency: 2 sync flops + DEBOUNCE_CYCLES stable cycles + 1 to the press pulse.
// Backpressure: none; free-running, the pulse is a single cycle and must be caught by the consumer.
module btn_debounce
    import video_timing_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic btn,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync0;
    logic          r_sync1;
    logic          r_stable;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // Two-flop synchroniser; idles high so reset looks like a released button.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_sync0 <= 1'b1;
            r_sync1 <= 1'b1;
        end else begin
            r_sync0 <= btn;
            r_sync1 <= r_sync0;
        end
    end

    // Accept a new level only after it has differed from the stable level for
    // DEBOUNCE_CYCLES consecutive cycles; any return to the stable level restarts.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cnt    <= '0;
            r_stable <= 1'b1;
            r_press  <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync1 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync1;
                r_cnt    <= '0;
                r_press  <= r_stable & ~r_sync1;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign press = r_press;

endmodule

// File: rtl/video_pattern_gen.sv
// Purpose: 640x480@60 raster timing plus a button-selectable RGB test pattern for the TMDS encoders.
// Latency: all outputs registered, one cycle after the counters hold the pixel position.
// Backpressure: none; the raster free-runs at the pixel clock.
module video_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE        = H_ACTIVE_DEF,
    parameter int H_FP            = H_FP_DEF,
    parameter int H_SYNC          = H_SYNC_DEF,
    parameter int H_BP            = H_BP_DEF,
    parameter int V_ACTIVE        = V_ACTIVE_DEF,
    parameter int V_FP            = V_FP_DEF,
    parameter int V_SYNC          = V_SYNC_DEF,
    parameter int V_BP            = V_BP_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       btn,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       frame_start,
    output logic [1:0] pattern
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic [1:0]       r_pattern;
    logic             r_pending;

    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    rgb_t             r_rgb;
    logic             r_frame_start;
    logic [1:0]       r_pattern_out;

    logic             w_press;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_wrap;
    logic             w_active;
    logic             w_hsync_n;
    logic             w_vsync_n;
    logic             w_origin;
    logic [2:0]       w_bar;
    rgb_t             w_pix;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .btn    (btn),
        .press  (w_press)
    );

    assign w_h_last  = (r_h_cnt == H_LAST);
    assign w_v_last  = (r_v_cnt == V_LAST);
    assign w_wrap    = w_h_last & w_v_last;
    assign w_active  = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hsync_n = !((r_h_cnt >= H_SS) && (r_h_cnt <= H_SE));
    assign w_vsync_n = !((r_v_cnt >= V_SS) && (r_v_cnt <= V_SE));
    assign w_origin  = (r_h_cnt == '0) && (r_v_cnt == '0);

    // Raster counters: h wraps every line, v advances on each h wrap.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + CNT_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + CNT_W'(1);
        end
    end

    // Presses are latched as pending and applied only on the frame wrap; a
    // press landing on the wrap cycle itself is kept for the following frame.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_pattern <= PAT_BARS;
            r_pending <= 1'b0;
        end else if (w_wrap) begin
            if (r_pending) begin
                r_pattern <= r_pattern + 2'd1;
            end
            r_pending <= w_press;
        end else if (w_press) begin
            r_pending <= 1'b1;
        end
    end

    // Colour-bar index from a compare chain (80 px per bar).
    always_comb begin
        w_bar = 3'd7;
        if      (r_h_cnt < 10'd80)  w_bar = 3'd0;
        else if (r_h_cnt < 10'd160) w_bar = 3'd1;
        else if (r_h_cnt < 10'd240) w_bar = 3'd2;
        else if (r_h_cnt < 10'd320) w_bar = 3'd3;
        else if (r_h_cnt < 10'd400) w_bar = 3'd4;
        else if (r_h_cnt < 10'd480) w_bar = 3'd5;
        else if (r_h_cnt < 10'd560) w_bar = 3'd6;
    end

    // Pixel colour for the current position; black whenever outside the active area.
    always_comb begin
        w_pix = RGB_BLACK;
        if (w_active) begin
            case (r_pattern)
                PAT_BARS:  w_pix = bar_colour(w_bar);
                PAT_CHECK: w_pix = (r_h_cnt[5] ^ r_v_cnt[5]) ? RGB_WHITE : RGB_BLACK;
                PAT_RAMP:  w_pix = {r_h_cnt[9:2], r_h_cnt[9:2], r_h_cnt[9:2]};
                PAT_WHITE: w_pix = RGB_WHITE;
                default:   w_pix = RGB_BLACK;
            endcase
        end
    end

    // Output register stage keeps sync, de, colour and pattern mutually aligned.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_de          <= 1'b0;
            r_rgb         <= RGB_BLACK;
            r_frame_start <= 1'b0;
            r_pattern_out <= PAT_BARS;
        end else begin
            r_hsync       <= w_hsync_n;
            r_vsync       <= w_vsync_n;
            r_de          <= w_active;
            r_rgb         <= w_pix;
            r_frame_start <= w_origin;
            r_pattern_out <= r_pattern;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign red         = r_rgb.red;
    assign green       = r_rgb.green;
    assign blue        = r_rgb.blue;
    assign frame_start = r_frame_start;
    assign pattern     = r_pattern_out;

endmodule
